// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// dmem_pkg : shared constants and dump FSM state type for the data memory
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 1 << ADDR_W;

  // Word count for a full-memory window; needs one bit more than an address.
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
//------------------------------------------------------------------------------
// dmem_array : DEPTH x DATA_W storage, one sync write port, two async reads
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_array
  import dmem_pkg::*;
(
  input  logic              Clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [0:DATA_W-1] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [0:DATA_W-1] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [0:DATA_W-1] rd_data_b
);

  // Name kept as MEM so existing memory-image preloads continue to find it.
  logic [0:DATA_W-1] MEM [0:DEPTH-1];

  always_ff @(posedge Clock) begin
    if (wr_en) begin
      MEM[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = MEM[rd_addr_a];
  assign rd_data_b = MEM[rd_addr_b];

endmodule

`default_nettype wire

// File: rtl/dmem_dump_port.sv
//------------------------------------------------------------------------------
// dmem_dump_port : processor data memory with a valid/ready window dump port
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_dump_port
  import dmem_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              memEn,
  input  logic              memWrEn,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [0:DATA_W-1] dataIn,
  output logic [0:DATA_W-1] dataOut,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W-1:0] dump_count,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [0:DATA_W-1] dump_data,
  output logic              dump_last,
  output logic              dump_busy,
  output logic              dump_done
);

  dump_state_t       r_state;
  dump_state_t       w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic [0:DATA_W-1] w_proc_rd;
  logic [0:DATA_W-1] w_dump_rd;
  logic              w_load;
  logic              w_finish;

  dmem_array u_array (
    .Clock     (Clock),
    .wr_en     (memEn & memWrEn),
    .wr_addr   (memAddr),
    .wr_data   (dataIn),
    .rd_addr_a (memAddr),
    .rd_data_a (w_proc_rd),
    .rd_addr_b (r_ptr),
    .rd_data_b (w_dump_rd)
  );

  assign dataOut = (memEn & ~memWrEn) ? w_proc_rd : '0;

  // Output register refills whenever it is empty or being drained this edge.
  assign w_load   = (r_state == RUN) && (r_remaining != '0) && (~dump_valid | dump_ready);
  assign w_finish = (r_state == RUN) && (r_remaining == '0) && dump_valid && dump_ready;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    dump_busy = 1'b0;
    dump_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (dump_start) begin
          w_next = RUN;
        end
      end
      RUN: begin
        dump_busy = 1'b1;
        if (w_finish) begin
          w_next = DONE;
        end
      end
      DONE: begin
        dump_busy = 1'b1;
        dump_done = 1'b1;
        w_next    = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // The dump read is sampled before this edge's processor write lands,
  // so a same-address collision captures the old word.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      dump_valid  <= 1'b0;
      dump_last   <= 1'b0;
      dump_addr   <= '0;
      dump_data   <= '0;
    end else if ((r_state == IDLE) && dump_start) begin
      r_ptr       <= dump_base;
      r_remaining <= (dump_count == '0) ? DEPTH_CNT : {1'b0, dump_count};
    end else if (w_load) begin
      dump_addr   <= r_ptr;
      dump_data   <= w_dump_rd;
      dump_valid  <= 1'b1;
      dump_last   <= (r_remaining == (ADDR_W+1)'(1));
      r_ptr       <= r_ptr + ADDR_W'(1);
      r_remaining <= r_remaining - (ADDR_W+1)'(1);
    end else if (w_finish) begin
      dump_valid  <= 1'b0;
      dump_last   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_dump_port.sv
//------------------------------------------------------------------------------
// tb_dmem_dump_port : directed self-checking bench for dmem_dump_port
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_dump_port;
  import dmem_pkg::*;

  logic        Clock      = 1'b0;
  logic        Reset      = 1'b0;
  logic        memEn      = 1'b0;
  logic        memWrEn    = 1'b0;
  logic [7:0]  memAddr    = '0;
  logic [0:63] dataIn     = '0;
  logic [0:63] dataOut;
  logic        dump_start = 1'b0;
  logic [7:0]  dump_base  = '0;
  logic [7:0]  dump_count = '0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [7:0]  dump_addr;
  logic [0:63] dump_data;
  logic        dump_last;
  logic        dump_busy;
  logic        dump_done;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model [0:255];

  dmem_dump_port dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .memEn      (memEn),
    .memWrEn    (memWrEn),
    .memAddr    (memAddr),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .dump_start (dump_start),
    .dump_base  (dump_base),
    .dump_count (dump_count),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic proc_write(input logic [7:0] a, input logic [63:0] d);
    memEn   = 1'b1;
    memWrEn = 1'b1;
    memAddr = a;
    dataIn  = d;
    tick();
    memEn   = 1'b0;
    memWrEn = 1'b0;
    model[a] = d;
  endtask

  // Runs one window; toggle selects ready pattern 1010..., start_mid pulses a stray start.
  task automatic do_dump(input logic [7:0] base, input int n, input bit toggle, input bit start_mid);
    int          idx;
    int          cyc;
    bit          held;
    logic [7:0]  p_addr;
    logic [63:0] p_data;
    logic        p_last;
    logic [7:0]  ea;
    idx    = 0;
    cyc    = 0;
    held   = 1'b0;
    p_addr = '0;
    p_data = '0;
    p_last = 1'b0;
    dump_base  = base;
    dump_count = n[7:0];
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("busy_after_start", 64'(dump_busy), 64'd1);
    check("valid_after_start", 64'(dump_valid), 64'd0);
    while (idx < n && cyc < 2000) begin
      dump_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (start_mid && cyc == 5) begin
        dump_start = 1'b1;
        dump_base  = 8'h77;
        dump_count = 8'd1;
      end else begin
        dump_start = 1'b0;
      end
      if (dump_valid) begin
        if (held) begin
          check("hold_addr", 64'(dump_addr), 64'(p_addr));
          check("hold_data", dump_data, p_data);
          check("hold_last", 64'(dump_last), 64'(p_last));
        end
        if (dump_ready) begin
          ea = base + idx[7:0];
          check("dump_addr", 64'(dump_addr), 64'(ea));
          check("dump_data", dump_data, model[ea]);
          check("dump_last", 64'(dump_last), 64'(idx == n - 1));
          idx++;
        end
        held   = !dump_ready;
        p_addr = dump_addr;
        p_data = dump_data;
        p_last = dump_last;
      end
      tick();
      cyc++;
    end
    dump_start = 1'b0;
    check("words_sent", 64'(idx), 64'(n));
    if (!toggle) begin
      check("stream_cycles", 64'(cyc), 64'(n + 1));
    end
    check("done_pulse", 64'(dump_done), 64'd1);
    check("valid_after_last", 64'(dump_valid), 64'd0);
    tick();
    check("done_one_cycle", 64'(dump_done), 64'd0);
    check("busy_after_done", 64'(dump_busy), 64'd0);
    tick();
    check("idle_no_restart", 64'(dump_valid | dump_busy | dump_done), 64'd0);
  endtask

  initial begin
    #1;
    check("rst_valid", 64'(dump_valid), 64'd0);
    check("rst_last",  64'(dump_last),  64'd0);
    check("rst_busy",  64'(dump_busy),  64'd0);
    check("rst_done",  64'(dump_done),  64'd0);
    check("rst_addr",  64'(dump_addr),  64'd0);
    check("rst_data",  dump_data,       64'd0);
    #10;
    Reset = 1'b1;
    tick();

    // Processor port write / read / disabled read
    proc_write(8'h10, 64'hDEAD_BEEF_0000_0001);
    memEn   = 1'b1;
    memWrEn = 1'b0;
    memAddr = 8'h10;
    #1;
    check("proc_read", dataOut, 64'hDEAD_BEEF_0000_0001);
    memWrEn = 1'b1;
    #1;
    check("proc_read_during_write", dataOut, 64'd0);
    memEn   = 1'b0;
    memWrEn = 1'b0;
    #1;
    check("proc_disabled", dataOut, 64'd0);

    // Preload MEM[i] = i through the processor port
    for (int i = 0; i < 256; i++) begin
      proc_write(i[7:0], 64'(i));
    end

    do_dump(8'd0,   4,   1'b0, 1'b0);
    do_dump(8'd250, 10,  1'b1, 1'b0);
    do_dump(8'h40,  256, 1'b0, 1'b1);

    // Same-edge collision on address 5
    dump_ready = 1'b1;
    dump_base  = 8'd4;
    dump_count = 8'd2;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    check("coll_first_addr", 64'(dump_addr), 64'd4);
    memEn   = 1'b1;
    memWrEn = 1'b1;
    memAddr = 8'd5;
    dataIn  = 64'hA5A5_5A5A_0F0F_F0F0;
    tick();
    memEn   = 1'b0;
    memWrEn = 1'b0;
    model[5] = 64'hA5A5_5A5A_0F0F_F0F0;
    check("coll_addr", 64'(dump_addr), 64'd5);
    check("coll_old_data", dump_data, 64'd5);
    check("coll_last", 64'(dump_last), 64'd1);
    tick();
    check("coll_done", 64'(dump_done), 64'd1);
    tick();
    memEn   = 1'b1;
    memWrEn = 1'b0;
    memAddr = 8'd5;
    #1;
    check("coll_new_read", dataOut, 64'hA5A5_5A5A_0F0F_F0F0);
    memEn = 1'b0;

    // Reset in the middle of a window
    dump_base  = 8'd0;
    dump_count = 8'd20;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_valid", 64'(dump_valid), 64'd1);
    Reset = 1'b0;
    #1;
    check("async_rst_valid", 64'(dump_valid), 64'd0);
    check("async_rst_busy",  64'(dump_busy),  64'd0);
    tick();
    check("rst_no_done", 64'(dump_done), 64'd0);
    tick();
    Reset = 1'b1;
    tick();
    check("post_rst_done", 64'(dump_done), 64'd0);
    check("post_rst_valid", 64'(dump_valid), 64'd0);
    memEn   = 1'b1;
    memWrEn = 1'b0;
    memAddr = 8'd3;
    #1;
    check("array_kept_3", dataOut, model[3]);
    memAddr = 8'd5;
    #1;
    check("array_kept_5", dataOut, model[5]);
    memEn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_dump_port.md
# dmem_dump_port

Data-memory responder for the cardinal processor's data port, with a second streaming read port for draining memory contents. Serves the processor's memEn/memWrEn/memAddr/dataIn/dataOut requests against a 256 x 64-bit array. Streams any address window out over a valid/ready channel to a dump sink (bench monitor, scan-out or debug link) while the processor keeps running. Replaces hierarchical memory peeking at end of simulation; synthesizes as-is.

## Interface
- DEPTH, 256, number of 64-bit words; must be 2**ADDR_W
- ADDR_W, 8, address width, matches processor Mem_Addr
- DATA_W, 64, word width, bit 0 = MSB (big-endian [0:DATA_W-1] ordering throughout)
- Clock  in  1  single system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; clears FSM and dump outputs, never the array
- memEn  in  1  processor access enable
- memWrEn  in  1  processor write enable (qualified by memEn)
- memAddr  in  ADDR_W  processor word address
- dataIn  in  DATA_W  processor write data
- dataOut  out  DATA_W  processor read data
- dump_start  in  1  one-cycle request to begin a dump
- dump_base  in  ADDR_W  first address of window, sampled with dump_start
- dump_count  in  ADDR_W  words to send; 0 means DEPTH
- dump_valid  out  1  dump word present
- dump_ready  in  1  sink accepts word
- dump_addr  out  ADDR_W  address of presented word
- dump_data  out  DATA_W  presented word
- dump_last  out  1  presented word is final of window
- dump_busy  out  1  dump in progress (start accepted, done not yet pulsed)
- dump_done  out  1  one-cycle pulse after final handshake

## Operation
- Processor port: write MEM[memAddr] <= dataIn at rising edge when memEn & memWrEn. dataOut = MEM[memAddr] combinationally when memEn & ~memWrEn, else all zeros.
- FSM states IDLE, RUN, DONE.
- IDLE: dump_busy=0. dump_start=1 latches ptr<=dump_base, remaining<=(dump_count==0 ? DEPTH : dump_count); next RUN.
- RUN: output register loads (dump_addr<=ptr, dump_data<=MEM[ptr], dump_valid<=1, dump_last<=(remaining==1)) on any edge where remaining>0 and (~dump_valid | dump_ready); ptr increments mod DEPTH, remaining decrements. If remaining==0 and the edge completes a handshake, dump_valid<=0 and go DONE.
- DONE: dump_done=1 for exactly one cycle, dump_busy=0 from the next cycle; next IDLE.
- dump_start while not IDLE: ignored, no effect on window.
- Address wrap: ptr wraps 255->0; base 250, count 10 sends 250..255,0..3.
- Snapshot rule: dump_data is a registered copy and holds while valid & ~ready, even if the processor later writes that address.
- Same-edge collision: processor write and dump capture of the same address on one edge -> dump_data gets the OLD word.
- remaining is ADDR_W+1 bits so DEPTH fits.

## Timing
- Reset (async assert): state IDLE, dump_valid=0, dump_last=0, dump_busy=0, dump_done=0, dump_addr=0, dump_data=0. dataOut follows array combinationally; contents undefined or preloaded (readmemh), never cleared.
- Reset mid-dump: window abandoned immediately, no dump_done pulse.
- dump_start sampled at edge k -> dump_busy high after k; first dump_valid high after edge k+1.
- With dump_ready held 1: one word per cycle, N words in N cycles after first valid; dump_done high the cycle after the final handshake edge.
- dump_ready low: valid, addr, data, last stable until accepted (AXI-style; valid never drops without handshake).
- Processor port has zero added latency; dump never stalls it.

## Structure
- Package dmem_pkg: ADDR_W, DATA_W, DEPTH constants; FSM state enum (IDLE, RUN, DONE).
- Sub-module dmem_array: DEPTH x DATA_W, one sync write port, two async read ports (processor, dump). Array named MEM so readmemh preloading keeps working.
- Top holds FSM, ptr/remaining counters, output register.

## Test plan
- Processor write 64'hDEAD_BEEF_0000_0001 to addr 8'h10, read back -> dataOut equals it; memEn=0 -> dataOut=0.
- Preload MEM[i]=i; start base 0, count 4, ready=1 -> 4 words 0..3 on consecutive cycles, last on addr 3, done pulses once, busy low after.
- Base 250, count 10, ready toggling 1010 -> addrs 250..255,0..3 in order, each held stable while ready=0, no duplicates or drops.
- Count 0 -> 256 words, last on addr base-1 mod 256; dump_start mid-dump ignored.
- Processor writes addr 5 on the capture edge of addr 5 -> dump_data shows old value; later read shows new.
- Reset low during RUN -> dump_valid/busy drop asynchronously, no done pulse; array contents intact afterward.
